// File: rtl/add_subb_pipe_if.sv
// Operation/result handshake bundle for the pipelined adder/subtractor.
// The master drives operations and out_ready; the slave returns results.
interface add_subb_pipe_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic         subb_a;
    logic         subb_b;
    logic         sat_en;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         c;
    logic         ovf;

    modport master (
        output in_valid, subb_a, subb_b, sat_en, a, b, out_ready,
        input  in_ready, out_valid, s, c, ovf
    );

    modport slave (
        input  in_valid, subb_a, subb_b, sat_en, a, b, out_ready,
        output in_ready, out_valid, s, c, ovf
    );
endinterface

// File: rtl/add_subb_pipe.sv
// Pipelined two's complement adder/subtractor s = +/-a +/-b, one L-bit ripple
// segment per stage, with valid/ready flow control, overflow and saturation.
module add_subb_pipe #(
    parameter int W = 64,
    parameter int S = 4
) (
    input  logic           clk,
    input  logic           arst,
    add_subb_pipe_if.slave bus
);
    localparam int L = W / S;
    localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

    logic         valid_q [S];
    logic         valid_d [S];
    logic         sat_q   [S];
    logic         sat_d   [S];
    logic [1:0]   cy_q    [S];
    logic [1:0]   cy_d    [S];
    logic [W-1:0] a_q     [S];
    logic [W-1:0] a_d     [S];
    logic [W-1:0] b_q     [S];
    logic [W-1:0] b_d     [S];
    logic [W-1:0] sum_q   [S];
    logic [W-1:0] sum_d   [S];
    logic         c_q, c_d;
    logic         ovf_q, ovf_d;
    logic         advance;

    logic         src_valid, src_sat, ovf_t, c_t;
    logic [1:0]   src_cy;
    logic [W-1:0] src_a, src_b, src_sum, merged;
    logic [L-1:0] seg_a, seg_b;
    logic [L+1:0] seg, top;
    int           p;

    assign advance        = ~valid_q[S-1] | bus.out_ready;
    assign bus.in_ready   = advance;
    assign bus.out_valid  = valid_q[S-1];
    assign bus.s          = sum_q[S-1];
    assign bus.c          = c_q;
    assign bus.ovf        = ovf_q;

    // Per-stage segment add; data registers only load for valid entries so
    // bubbles leave the last result (or the reset zeros) untouched.
    always_comb begin
        src_valid = 1'b0;
        src_sat   = 1'b0;
        src_cy    = 2'd0;
        src_a     = {W{1'b0}};
        src_b     = {W{1'b0}};
        src_sum   = {W{1'b0}};
        merged    = {W{1'b0}};
        seg_a     = {L{1'b0}};
        seg_b     = {L{1'b0}};
        seg       = {(L+2){1'b0}};
        top       = {(L+2){1'b0}};
        ovf_t     = 1'b0;
        c_t       = 1'b0;
        p         = 0;
        c_d       = c_q;
        ovf_d     = ovf_q;
        for (int k = 0; k < S; k++) begin
            valid_d[k] = valid_q[k];
            sat_d[k]   = sat_q[k];
            cy_d[k]    = cy_q[k];
            a_d[k]     = a_q[k];
            b_d[k]     = b_q[k];
            sum_d[k]   = sum_q[k];
        end
        for (int k = 0; k < S; k++) begin
            p = (k > 0) ? k - 1 : 0;
            if (k == 0) begin
                src_valid = bus.in_valid;
                src_sat   = bus.sat_en;
                src_a     = bus.a ^ {W{bus.subb_a}};
                src_b     = bus.b ^ {W{bus.subb_b}};
                src_cy    = {1'b0, bus.subb_a} + {1'b0, bus.subb_b};
                src_sum   = {W{1'b0}};
            end else begin
                src_valid = valid_q[p];
                src_sat   = sat_q[p];
                src_a     = a_q[p];
                src_b     = b_q[p];
                src_cy    = cy_q[p];
                src_sum   = sum_q[p];
            end
            seg_a = src_a[k*L +: L];
            seg_b = src_b[k*L +: L];
            seg   = {2'b00, seg_a} + {2'b00, seg_b} + {{L{1'b0}}, src_cy};
            merged = src_sum;
            merged[k*L +: L] = seg[L-1:0];
            // Top segment: sign-extended sum gives bits W+1..W-1 of the true result.
            if (k == S - 1) begin
                top   = {{2{seg_a[L-1]}}, seg_a} + {{2{seg_b[L-1]}}, seg_b}
                      + {{L{1'b0}}, src_cy};
                ovf_t = ~((top[L+1] == top[L]) & (top[L] == top[L-1]));
                c_t   = |seg[L+1:L];
                if (src_sat & ovf_t) begin
                    merged = top[L+1] ? SAT_NEG : SAT_POS;
                end else begin
                    merged = merged;
                end
            end else begin
                top = {(L+2){1'b0}};
            end
            if (advance) begin
                valid_d[k] = src_valid;
                if (src_valid) begin
                    sat_d[k] = src_sat;
                    cy_d[k]  = seg[L+1:L];
                    a_d[k]   = src_a;
                    b_d[k]   = src_b;
                    sum_d[k] = merged;
                    if (k == S - 1) begin
                        c_d   = c_t;
                        ovf_d = ovf_t;
                    end else begin
                        c_d   = c_d;
                    end
                end else begin
                    sum_d[k] = sum_q[k];
                end
            end else begin
                valid_d[k] = valid_q[k];
            end
        end
    end

    // Stage registers; reset discards everything in flight.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int k = 0; k < S; k++) begin
                valid_q[k] <= 1'b0;
                sat_q[k]   <= 1'b0;
                cy_q[k]    <= 2'd0;
                a_q[k]     <= {W{1'b0}};
                b_q[k]     <= {W{1'b0}};
                sum_q[k]   <= {W{1'b0}};
            end
            c_q   <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < S; k++) begin
                valid_q[k] <= valid_d[k];
                sat_q[k]   <= sat_d[k];
                cy_q[k]    <= cy_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                sum_q[k]   <= sum_d[k];
            end
            c_q   <= c_d;
            ovf_q <= ovf_d;
        end
    end
endmodule
